// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the host-side debug command bridge.
// The DBG_TIMEOUT_EN build adds a WAIT-state watchdog to dbg_host_bridge.
package dbg_bridge_pkg;

  typedef enum logic [2:0] {
    ST_RX_CMD  = 3'd0,
    ST_RX_ADDR = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_WAIT    = 3'd3,
    ST_TX      = 3'd4
  } state_t;

  localparam logic [7:0] DBG_ST_OK      = 8'h00;
  localparam logic [7:0] DBG_ST_NOP     = 8'h01;
  localparam logic [7:0] DBG_ST_TIMEOUT = 8'hEE;
  localparam logic [7:0] DBG_CMD_NOP    = 8'h00;

  localparam int REQ_BYTES = 9;
  localparam int RSP_BYTES = 5;

  // Index of the last byte in a 4-byte request field and in the response frame.
  localparam logic [2:0] FIELD_LAST = 3'(((REQ_BYTES - 1) / 2) - 1);
  localparam logic [2:0] RSP_LAST   = 3'(RSP_BYTES - 1);

endpackage

// File: rtl/dbg_host_bridge.sv
// Host byte-stream to debug command port bridge: 9-byte request in, 5-byte response out.
// Optional macro DBG_TIMEOUT_EN bounds the wait for dbg_ready_i to TIMEOUT_CYCLES.
module dbg_host_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o
);

  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  cnt_r;
  logic [7:0]  cmd_r;
  logic [7:0]  dbg_cmd_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [39:0] rsp_r;
  logic        rx_ready_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        rx_acc_s;
  logic        tx_acc_s;
  logic        ready_hit_s;
  logic        timeout_hit_s;

`ifdef DBG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] wait_cnt_r;
`endif

  assign rx_ready_o = rx_ready_r;
  assign tx_valid_o = tx_valid_r;
  assign tx_data_o  = rsp_r[7:0];
  assign dbg_cmd_o  = dbg_cmd_r;
  assign dbg_addr_o = addr_r;
  assign dbg_data_o = data_r;
  assign busy_o     = busy_r;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_RX_CMD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and handshake qualification.
  always_comb begin
    state_next_s  = state_r;
    rx_acc_s      = rx_valid_i & rx_ready_r;
    tx_acc_s      = tx_valid_r & tx_ready_i;
    ready_hit_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_RX_CMD: begin
        if (rx_acc_s) begin
          state_next_s = ST_RX_ADDR;
        end else begin
          state_next_s = ST_RX_CMD;
        end
      end
      ST_RX_ADDR: begin
        if (rx_acc_s && (cnt_r == FIELD_LAST)) begin
          state_next_s = ST_RX_DATA;
        end else begin
          state_next_s = ST_RX_ADDR;
        end
      end
      ST_RX_DATA: begin
        if (rx_acc_s && (cnt_r == FIELD_LAST)) begin
          if (cmd_r == DBG_CMD_NOP) begin
            state_next_s = ST_TX;
          end else begin
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_RX_DATA;
        end
      end
      ST_WAIT: begin
        // cnt_r stays 0 only in the first WAIT cycle, where dbg_ready_i is ignored.
        if ((cnt_r != 3'd0) && dbg_ready_i) begin
          ready_hit_s  = 1'b1;
          state_next_s = ST_TX;
        end
`ifdef DBG_TIMEOUT_EN
        else if (wait_cnt_r == TMO_LAST) begin
          timeout_hit_s = 1'b1;
          state_next_s  = ST_TX;
        end
`endif
        else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_TX: begin
        if (tx_acc_s && (cnt_r == RSP_LAST)) begin
          state_next_s = ST_RX_CMD;
        end else begin
          state_next_s = ST_TX;
        end
      end
      default: begin
        state_next_s = ST_RX_CMD;
      end
    endcase
  end

  // Frame assembly, command issue, response capture and registered stream flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r      <= 3'd0;
      cmd_r      <= 8'h00;
      dbg_cmd_r  <= 8'h00;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      rsp_r      <= 40'h00_0000_0000;
      rx_ready_r <= 1'b0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (state_next_s != state_r) begin
        cnt_r <= 3'd0;
      end else if ((state_r == ST_RX_ADDR || state_r == ST_RX_DATA) && rx_acc_s) begin
        cnt_r <= cnt_r + 3'd1;
      end else if (state_r == ST_TX && tx_acc_s) begin
        cnt_r <= cnt_r + 3'd1;
      end else if (state_r == ST_WAIT && cnt_r == 3'd0) begin
        cnt_r <= 3'd1;
      end

      if (state_r == ST_RX_CMD && rx_acc_s) begin
        cmd_r <= rx_data_i;
      end
      // Little-endian fields: each new byte enters at the top and slides down.
      if (state_r == ST_RX_ADDR && rx_acc_s) begin
        addr_r <= {rx_data_i, addr_r[31:8]};
      end
      if (state_r == ST_RX_DATA && rx_acc_s) begin
        data_r <= {rx_data_i, data_r[31:8]};
      end

      if (state_r == ST_RX_DATA && state_next_s == ST_WAIT) begin
        dbg_cmd_r <= cmd_r;
      end else if (state_r == ST_WAIT && state_next_s == ST_TX) begin
        dbg_cmd_r <= DBG_CMD_NOP;
      end

      if (ready_hit_s) begin
        rsp_r <= {dbg_data_i, DBG_ST_OK};
      end else if (timeout_hit_s) begin
`ifdef DBG_TIMEOUT_EN
        rsp_r <= {32'h0000_0000, DBG_ST_TIMEOUT};
`else
        rsp_r <= rsp_r;
`endif
      end else if (state_r == ST_RX_DATA && state_next_s == ST_TX) begin
        rsp_r <= {32'h0000_0000, DBG_ST_NOP};
      end else if (tx_acc_s) begin
        rsp_r <= {8'h00, rsp_r[39:8]};
      end

      rx_ready_r <= (state_next_s == ST_RX_CMD) || (state_next_s == ST_RX_ADDR) ||
                    (state_next_s == ST_RX_DATA);
      tx_valid_r <= (state_next_s == ST_TX);
      busy_r     <= (state_next_s != ST_RX_CMD);
    end
  end

`ifdef DBG_TIMEOUT_EN
  // WAIT-cycle watchdog; restarts whenever WAIT is left.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT && state_next_s == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= '0;
    end
  end
`endif

endmodule

// File: doc/dbg_host_bridge.md
Name: dbg_host_bridge

Overview:
Host-side initiator for the core debug command interface. It receives a framed byte stream from a host link (UART/JTAG front-end, valid/ready byte streams) and assembles command, address and data. It drives the debug command port, waits for completion, then returns a status byte and 32-bit read data on the outgoing byte stream. It sits between the host transport and the debug module inside the top-level wrapper.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waited for dbg_ready_i per command; used only when DBG_TIMEOUT_EN is defined; must be >= 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
rx_data_i  in  8  incoming host byte
rx_valid_i  in  1  rx byte valid
rx_ready_o  out  1  bridge accepts rx byte
tx_data_o  out  8  outgoing response byte
tx_valid_o  out  1  tx byte valid
tx_ready_i  in  1  host accepts tx byte
dbg_cmd_o  out  8  debug command; 0x00 = none
dbg_addr_o  out  32  debug address
dbg_data_o  out  32  debug write data
dbg_data_i  in  32  debug read data
dbg_ready_i  in  1  debug module done/ready
busy_o  out  1  high outside RX_CMD state

Behaviour:
- Stream transfer occurs on a rising edge with valid & ready both high. tx_data_o/tx_valid_o stay stable until accepted.
- Request frame is 9 bytes: cmd, addr[7:0]..addr[31:24], data[7:0]..data[31:24] (little-endian).
- Response frame is 5 bytes: status, rdata[7:0]..rdata[31:24].
- Status codes: 0x00 ok, 0x01 NOP, 0xEE timeout.
- FSM states: RX_CMD -> RX_ADDR (4 bytes) -> RX_DATA (4 bytes) -> WAIT -> TX (5 bytes) -> RX_CMD.
  - A 3-bit byte counter indexes RX_ADDR, RX_DATA and TX; it clears on each state entry.
- rx_ready_o is high only in RX_*. tx_valid_o is high only in TX.
- Gaps in rx_valid_i or tx_ready_i stall the FSM with no state change.
- Issue latency:
  - dbg_cmd_o, dbg_addr_o and dbg_data_o are registered.
  - dbg_cmd_o becomes the received cmd on the edge that accepts the last data byte (first WAIT cycle).
  - All three outputs hold constant throughout WAIT.
- Completion:
  - dbg_ready_i is ignored in the first WAIT cycle and sampled from the second cycle on.
  - On the first sampled high, dbg_data_i is captured into the response register with status 0x00.
  - On that same edge, dbg_cmd_o returns to 0x00 and the FSM enters TX.
  - The first tx byte is therefore valid one cycle after ready is sampled.
- NOP: cmd 0x00 skips WAIT entirely (dbg_cmd_o never asserted) and sends response 01 00 00 00 00.
- Reset values: rx_ready_o 0 during reset, then 1 (RX_CMD); tx_valid_o 0; tx_data_o 0x00; dbg_cmd_o 0x00; dbg_addr_o 0; dbg_data_o 0; busy_o 0; response register 0.
- Reset mid-operation: everything returns immediately to reset values. Partial frames are discarded, and no response is sent.
- Rx bytes arriving while not in RX_* are not accepted (back-pressured), never dropped.

Optional Feature:
- Macro DBG_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If dbg_ready_i has not been sampled high by WAIT cycle TIMEOUT_CYCLES, dbg_cmd_o drops to 0x00 and the response becomes EE 00 00 00 00.
  - If ready and timeout occur in the same cycle, ready wins.
- Undefined: no counter; WAIT lasts indefinitely until dbg_ready_i.

Decomposition:
- Package dbg_bridge_pkg holds:
  - the state enum;
  - status codes DBG_ST_OK, DBG_ST_NOP, DBG_ST_TIMEOUT;
  - DBG_CMD_NOP;
  - frame lengths REQ_BYTES=9, RSP_BYTES=5.
- Single module; no sub-module is warranted (byte shifting is inline).

Test Plan:
- Read/write round trip:
  - Send 02 00 40 00 00 EF BE AD DE; ready high 3 cycles after issue with dbg_data_i=0x12345678.
  - Expect dbg_cmd_o=0x02, dbg_addr_o=0x00004000, dbg_data_o=0xDEADBEEF, then tx 00 78 56 34 12.
- Backpressure:
  - Hold tx_ready_i low 10 cycles during TX.
  - Expect the current byte stable, no byte lost or duplicated, and rx_ready_o=0 throughout.
- NOP: send 00 plus 8 bytes -> dbg_cmd_o stays 0x00, tx 01 00 00 00 00.
- Rx gaps: random 0–5 idle cycles between request bytes -> identical outputs to the round-trip test.
- Reset in WAIT:
  - Assert rst_i -> dbg_cmd_o=0x00 immediately and tx_valid_o=0.
  - After release, rx_ready_o=1 and the next frame completes normally.
- DBG_TIMEOUT_EN with TIMEOUT_CYCLES=16, dbg_ready_i held low -> after 16 WAIT cycles dbg_cmd_o=0x00, tx EE 00 00 00 00.
